// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX stage: forwarding selects, bubble control, update actions.
// The optional EX forwarding path is enabled by defining ID_EX_FWD_EN.
package id_ex_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REGW_DEF = 5;
  localparam int unsigned ALUOP_W  = 5;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'b00000;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic [1:0]         memtoreg;
    logic [ALUOP_W-1:0] aluop;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    regwrite: 1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 2'b00,
    aluop:    ALUOP_NOP
  };

  typedef enum logic [1:0] {
    UPD_CAPTURE,
    UPD_FLUSH,
    UPD_HOLD,
    UPD_BUBBLE
  } upd_e;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Per-operand forwarding select: MEM beats WB beats register data; x0 and in-flight loads never forward.
module fwd_sel
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] reg_data,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = reg_data;
    unique case (sel)
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_result;
      default: data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use bubble insertion.
// Define ID_EX_FWD_EN to enable MEM/WB forwarding; otherwise the hazard check covers every EX writer.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [4:0]      id_aluop,
  input  logic            id_alusrc_b,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic [1:0]      id_memtoreg,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [XLEN-1:0] mem_result,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_aluop,
  output logic [XLEN-1:0] ex_alu_a,
  output logic [XLEN-1:0] ex_alu_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [1:0]      ex_memtoreg,
  output logic            load_use_hazard
);

  logic            valid_q;
  ex_ctrl_t        ctrl_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [REGW-1:0] rs1_q;
  logic [REGW-1:0] rs2_q;
  logic [REGW-1:0] rd_q;
  logic            alusrc_b_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            hazard_src;
  upd_e            upd;

`ifdef ID_EX_FWD_EN
  fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
    .rs           (rs1_q),
    .reg_data     (rs1_data_q),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .data         (fwd_rs1)
  );

  fwd_sel #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
    .rs           (rs2_q),
    .reg_data     (rs2_data_q),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .mem_result   (mem_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .data         (fwd_rs2)
  );

  // Only loads need a bubble; ALU results reach EX through the MEM/WB paths.
  assign hazard_src = ctrl_q.memread;
`else
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  // Without forwarding every pending EX writer is a hazard.
  assign hazard_src = ctrl_q.regwrite;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_rd, mem_regwrite, mem_memread, mem_result,
                               wb_rd, wb_regwrite, wb_result, rs1_q, rs2_q};
`endif

  assign load_use_hazard = id_valid & valid_q & hazard_src & (rd_q != '0) &
                           ((id_rs1 == rd_q) | (id_rs2 == rd_q));

  always_comb begin
    upd = UPD_CAPTURE;
    if (flush) begin
      upd = UPD_FLUSH;
    end else if (stall) begin
      upd = UPD_HOLD;
    end else if (load_use_hazard) begin
      upd = UPD_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alusrc_b_q <= 1'b0;
    end else begin
      unique case (upd)
        UPD_FLUSH, UPD_BUBBLE: begin
          valid_q <= 1'b0;
          ctrl_q  <= BUBBLE_CTRL;
        end
        UPD_HOLD: begin
`ifdef ID_EX_FWD_EN
          // Refresh held operands so a producer retiring from WB mid-stall is kept.
          rs1_data_q <= fwd_rs1;
          rs2_data_q <= fwd_rs2;
`endif
        end
        default: begin
          valid_q    <= id_valid;
          ctrl_q     <= '{regwrite: id_regwrite,
                          memread:  id_memread,
                          memwrite: id_memwrite,
                          memtoreg: id_memtoreg,
                          aluop:    id_aluop};
          pc_q       <= id_pc;
          imm_q      <= id_imm;
          rs1_data_q <= id_rs1_data;
          rs2_data_q <= id_rs2_data;
          rs1_q      <= id_rs1;
          rs2_q      <= id_rs2;
          rd_q       <= id_rd;
          alusrc_b_q <= id_alusrc_b;
        end
      endcase
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_aluop      = ctrl_q.aluop;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;
  assign ex_alu_a      = fwd_rs1;
  assign ex_alu_b      = alusrc_b_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a reference model.
module tb_id_ex_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam logic [4:0] OP_ADD = 5'd1;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn, stall, flush, id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;
  logic [4:0]      id_aluop;
  logic            id_alusrc_b, id_regwrite, id_memread, id_memwrite;
  logic [1:0]      id_memtoreg;
  logic [REGW-1:0] mem_rd, wb_rd;
  logic            mem_regwrite, mem_memread, wb_regwrite;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_alu_a, ex_alu_b, ex_store_data;
  logic [4:0]      ex_aluop;
  logic [REGW-1:0] ex_rd;
  logic            ex_regwrite, ex_memread, ex_memwrite;
  logic [1:0]      ex_memtoreg;
  logic            load_use_hazard;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  id_ex_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluop(id_aluop),
    .id_alusrc_b(id_alusrc_b), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluop(ex_aluop), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .load_use_hazard(load_use_hazard)
  );

  always #5 clk = ~clk;

  // Reference view of the instruction sitting in EX.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  aluop;
    logic        alusrc;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
  } ex_t;

  ex_t m = '0;

  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] stored);
    if (FWD && r != 5'd0) begin
      if (mem_regwrite && !mem_memread && mem_rd == r) return mem_result;
      if (wb_regwrite && wb_rd == r) return wb_result;
    end
    return stored;
  endfunction

  function automatic logic hazard_exp();
    if (!id_valid || !m.valid || m.rd == 5'd0) return 1'b0;
    if (!(FWD ? m.mr : m.rw)) return 1'b0;
    return (id_rs1 == m.rd) || (id_rs2 == m.rd);
  endfunction

  task automatic tick();
    ex_t nx;
    nx = m;
    if (!rstn) begin
      nx = '0;
    end else if (flush || (!stall && hazard_exp())) begin
      nx.valid = 1'b0; nx.rw = 1'b0; nx.mr = 1'b0; nx.mw = 1'b0; nx.mtr = 2'b00; nx.aluop = 5'd0;
    end else if (stall) begin
      nx.v1 = operand(m.rs1, m.v1);
      nx.v2 = operand(m.rs2, m.v2);
    end else begin
      nx.valid = id_valid; nx.pc = id_pc; nx.imm = id_imm; nx.v1 = id_rs1_data; nx.v2 = id_rs2_data;
      nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd; nx.aluop = id_aluop; nx.alusrc = id_alusrc_b;
      nx.rw = id_regwrite; nx.mr = id_memread; nx.mw = id_memwrite; nx.mtr = id_memtoreg;
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic clear_inputs();
    rstn = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_aluop = '0; id_alusrc_b = 1'b0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; id_memtoreg = '0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_result = '0;
    wb_rd = '0; wb_regwrite = 1'b0; wb_result = '0;
  endtask

  task automatic empty_ex();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0; id_valid = 1'b1; id_pc = 32'h40; id_rs1 = 5'd3; id_rs1_data = 32'h1234_5678;
    id_rd = 5'd3; id_regwrite = 1'b1; id_memread = 1'b1; id_aluop = 5'd3; id_imm = 32'h77; id_alusrc_b = 1'b1;
    tick(); tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    n_tests++; if (ex_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", ex_pc); end
    n_tests++; if (ex_aluop !== 5'd0) begin n_fail++; $display("FAIL reset_aluop: got %h want 0", ex_aluop); end
    n_tests++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); end
    n_tests++; if (ex_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %h want 0", ex_rd); end
    n_tests++; if (ex_alu_a !== 32'h0) begin n_fail++; $display("FAIL reset_alu_a: got %h want 0", ex_alu_a); end
    n_tests++; if (ex_alu_b !== 32'h0) begin n_fail++; $display("FAIL reset_alu_b: got %h want 0", ex_alu_b); end
    n_tests++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL reset_store: got %h want 0", ex_store_data); end
    n_tests++; if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", load_use_hazard); end
    clear_inputs();
  endtask

  task automatic test_fwd_mem();
    logic [31:0] want;
    clear_inputs(); empty_ex();
    mem_rd = 5'd5; mem_regwrite = 1'b1; mem_result = 32'h0000_0010;
    id_valid = 1'b1; id_pc = 32'h100; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd6; id_aluop = OP_ADD;
    id_regwrite = 1'b1; id_rs1_data = 32'hDEAD_BEEF; id_rs2_data = 32'hDEAD_BEEF;
    tick();
    want = FWD ? 32'h0000_0010 : 32'hDEAD_BEEF;
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_mem_valid: got %b want 1", ex_valid); end
    n_tests++; if (ex_pc !== 32'h100) begin n_fail++; $display("FAIL fwd_mem_pc: got %h want 100", ex_pc); end
    n_tests++; if (ex_rd !== 5'd6 || ex_aluop !== OP_ADD) begin
      n_fail++; $display("FAIL fwd_mem_rd_op: got rd %0d op %0d want 6 %0d", ex_rd, ex_aluop, OP_ADD); end
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL fwd_mem_a: got %h want %h", ex_alu_a, want); end
    n_tests++; if (ex_alu_b !== want) begin n_fail++; $display("FAIL fwd_mem_b: got %h want %h", ex_alu_b, want); end
    n_tests++; if (ex_store_data !== want) begin n_fail++; $display("FAIL fwd_mem_store: got %h want %h", ex_store_data, want); end
  endtask

  task automatic test_double_producer();
    logic [31:0] want;
    clear_inputs(); empty_ex();
    id_valid = 1'b1; id_rs1 = 5'd7; id_rs2 = 5'd0; id_rd = 5'd8; id_regwrite = 1'b1;
    id_rs1_data = 32'h1111_1111; id_aluop = OP_ADD;
    mem_rd = 5'd7; mem_regwrite = 1'b1; mem_result = 32'hAAAA_0000;
    wb_rd = 5'd7; wb_regwrite = 1'b1; wb_result = 32'h5555_0000;
    tick();
    want = FWD ? 32'hAAAA_0000 : 32'h1111_1111;
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL double_mem_prio: got %h want %h", ex_alu_a, want); end
    mem_regwrite = 1'b0; #1;
    want = FWD ? 32'h5555_0000 : 32'h1111_1111;
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL double_wb_only: got %h want %h", ex_alu_a, want); end
    mem_regwrite = 1'b1; mem_memread = 1'b1; #1;
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL double_mem_load_skip: got %h want %h", ex_alu_a, want); end
  endtask

  task automatic test_x0_guard();
    clear_inputs(); empty_ex();
    mem_rd = 5'd0; mem_regwrite = 1'b1; mem_result = 32'hFFFF_FFFF;
    wb_rd = 5'd0; wb_regwrite = 1'b1; wb_result = 32'hFFFF_FFFF;
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd9; id_alusrc_b = 1'b1; id_imm = 32'h123;
    tick();
    n_tests++; if (ex_alu_a !== 32'h0) begin n_fail++; $display("FAIL x0_alu_a: got %h want 0", ex_alu_a); end
    n_tests++; if (ex_alu_b !== 32'h123) begin n_fail++; $display("FAIL x0_alu_b_imm: got %h want 123", ex_alu_b); end
    n_tests++; if (ex_store_data !== 32'h0) begin n_fail++; $display("FAIL x0_store: got %h want 0", ex_store_data); end
  endtask

  task automatic test_load_use();
    logic [31:0] want;
    clear_inputs(); empty_ex();
    id_valid = 1'b1; id_pc = 32'h200; id_rs1 = 5'd1; id_rs1_data = 32'h1000; id_imm = 32'h4; id_alusrc_b = 1'b1;
    id_rd = 5'd3; id_regwrite = 1'b1; id_memread = 1'b1; id_memtoreg = 2'b01; id_aluop = OP_ADD;
    tick();
    id_pc = 32'h204; id_rs1 = 5'd3; id_rs2 = 5'd1; id_rd = 5'd4; id_rs1_data = 32'h0BAD_0000;
    id_rs2_data = 32'h1000; id_alusrc_b = 1'b0; id_memread = 1'b0; id_memtoreg = 2'b00;
    #1;
    n_tests++; if (load_use_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_hazard_set: got %b want 1", load_use_hazard); end
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
    n_tests++; if ({ex_regwrite, ex_memread, ex_memwrite} !== 3'b000) begin
      n_fail++; $display("FAIL lu_bubble_ctrl: got %b want 000", {ex_regwrite, ex_memread, ex_memwrite}); end
    n_tests++; if (load_use_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_hazard_once: got %b want 0", load_use_hazard); end
    mem_rd = 5'd3; mem_regwrite = 1'b1; mem_memread = 1'b1; mem_result = 32'hDEAD_DEAD;
    tick();
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_rd = 5'd3; wb_regwrite = 1'b1; wb_result = 32'hCAFE_0003;
    #1;
    want = FWD ? 32'hCAFE_0003 : 32'h0BAD_0000;
    n_tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h204) begin
      n_fail++; $display("FAIL lu_recapture: got valid %b pc %h want 1 204", ex_valid, ex_pc); end
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL lu_wb_fwd: got %h want %h", ex_alu_a, want); end
    n_tests++; if (ex_alu_b !== 32'h1000) begin n_fail++; $display("FAIL lu_alu_b: got %h want 1000", ex_alu_b); end
  endtask

  task automatic test_stall_refresh();
    logic [31:0] want;
    clear_inputs(); empty_ex();
    id_valid = 1'b1; id_pc = 32'h300; id_rs1 = 5'd9; id_rs1_data = 32'h111; id_rd = 5'd10;
    id_regwrite = 1'b1; id_aluop = OP_ADD;
    tick();
    stall = 1'b1; id_pc = 32'h304; id_rs1 = 5'd11; id_rs1_data = 32'h999;
    wb_rd = 5'd9; wb_regwrite = 1'b1; wb_result = 32'h1234;
    tick();
    wb_rd = 5'd0; wb_regwrite = 1'b0;
    n_tests++; if (ex_pc !== 32'h300) begin n_fail++; $display("FAIL stall_hold_pc: got %h want 300", ex_pc); end
    tick(); tick();
    stall = 1'b0; id_valid = 1'b0; #1;
    want = FWD ? 32'h1234 : 32'h111;
    n_tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h300) begin
      n_fail++; $display("FAIL stall_release: got valid %b pc %h want 1 300", ex_valid, ex_pc); end
    n_tests++; if (ex_alu_a !== want) begin n_fail++; $display("FAIL stall_wb_refresh: got %h want %h", ex_alu_a, want); end
    stall = 1'b1; flush = 1'b1;
    tick();
    n_tests++; if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
      n_fail++; $display("FAIL flush_beats_stall: got valid %b rw %b want 0 0", ex_valid, ex_regwrite); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, es;
    clear_inputs();
    rstn = 1'b0; tick(); rstn = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 11) == 0);
      id_valid = ($urandom_range(0, 9) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_aluop = 5'($urandom_range(0, 31)); id_alusrc_b = 1'($urandom_range(0, 1));
      id_regwrite = 1'($urandom_range(0, 1)); id_memread = ($urandom_range(0, 2) == 0);
      id_memwrite = 1'($urandom_range(0, 1)); id_memtoreg = 2'($urandom_range(0, 3));
      mem_rd = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom_range(0, 1));
      mem_memread = ($urandom_range(0, 3) == 0); mem_result = $urandom;
      wb_rd = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom_range(0, 1)); wb_result = $urandom;
      #1;
      ea = operand(m.rs1, m.v1);
      es = operand(m.rs2, m.v2);
      eb = m.alusrc ? m.imm : es;
      n_tests++; if (ex_valid !== m.valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, ex_valid, m.valid); end
      n_tests++; if (load_use_hazard !== hazard_exp()) begin
        n_fail++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, load_use_hazard, hazard_exp()); end
      n_tests++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_aluop} !== {m.rw, m.mr, m.mw, m.mtr, m.aluop}) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
          {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_aluop}, {m.rw, m.mr, m.mw, m.mtr, m.aluop}); end
      if (m.valid) begin
        n_tests++; if (ex_pc !== m.pc || ex_rd !== m.rd) begin
          n_fail++; $display("FAIL rnd_pc_rd[%0d]: got %h/%0d want %h/%0d", i, ex_pc, ex_rd, m.pc, m.rd); end
        n_tests++; if (ex_alu_a !== ea) begin n_fail++; $display("FAIL rnd_alu_a[%0d]: got %h want %h", i, ex_alu_a, ea); end
        n_tests++; if (ex_alu_b !== eb) begin n_fail++; $display("FAIL rnd_alu_b[%0d]: got %h want %h", i, ex_alu_b, eb); end
        n_tests++; if (ex_store_data !== es) begin n_fail++; $display("FAIL rnd_store[%0d]: got %h want %h", i, ex_store_data, es); end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    test_reset();
    test_fwd_mem();
    test_double_producer();
    test_x0_guard();
    test_load_use();
    test_stall_refresh();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
